// File: rtl/shift_cmd_sequencer_pkg.sv
// shift_pkg: shared types for the shift command sequencer.
// Holds the opcode encoding, the sequencer FSM states and the packed
// command word that is stored in the command FIFO.
package shift_pkg;

    // Default geometry; the top-level parameters default to these values
    // and the packed command word below is sized from them.
    localparam int SEQ_WIDTH = 8;
    localparam int SEQ_DEPTH = 4;
    localparam int SEQ_CNT_W = 4;

    // Number of one-hot shifter control lines.
    localparam int NUM_CTRL  = 5;

    // Bit positions of the shifter controls inside the one-hot vector.
    // They line up with the opcode values so a legal opcode indexes its control.
    localparam int C_LOAD = 0;
    localparam int C_ROTL = 1;
    localparam int C_SHL  = 2;
    localparam int C_SHR  = 3;
    localparam int C_HOLD = 4;

    // Command opcodes; 5..7 are illegal and get dropped with an error pulse.
    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ROTL = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_HOLD = 3'd4
    } op_e;

    // Sequencer FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    // One queued command. The opcode is kept as raw bits so illegal
    // encodings survive the FIFO and can be flagged when popped.
    typedef struct packed {
        logic [2:0]           op;
        logic [SEQ_CNT_W-1:0] count;
        logic [SEQ_WIDTH-1:0] data;
    } cmd_t;

    // True for opcodes the shifter understands.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= 3'(OP_HOLD));
    endfunction

    // One-hot control vector for an opcode; all zero for illegal opcodes.
    function automatic logic [NUM_CTRL-1:0] op_onehot(input logic [2:0] op);
        logic [NUM_CTRL-1:0] v;
        v = '0;
        case (op)
            3'(OP_LOAD): v[C_LOAD] = 1'b1;
            3'(OP_ROTL): v[C_ROTL] = 1'b1;
            3'(OP_SHL):  v[C_SHL]  = 1'b1;
            3'(OP_SHR):  v[C_SHR]  = 1'b1;
            3'(OP_HOLD): v[C_HOLD] = 1'b1;
            default:     v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/shift_cmd_sequencer_sync_fifo.sv
// sync_fifo: single-clock FIFO of cmd_t words.
// Read and write pointers carry one extra wrap bit so that full and empty
// are told apart without a separate occupancy counter. Data is read
// combinationally from the head entry (show-ahead); pushes into a full
// FIFO and pops from an empty FIFO are ignored.
module sync_fifo
    import shift_pkg::*;
#(
    parameter int DEPTH = SEQ_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic pop_i,
    input  cmd_t wdata_i,
    output cmd_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    // Full when the index bits match but the wrap bits differ.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values: each advances by one on an accepted operation.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: command front-end for the 8-bit shift register.
// Commands are queued in a small FIFO and replayed onto the shifter's
// one-hot control lines for their repeat count, back to back with no
// bubbles. A predictor tracks what the shifter must contain each cycle.
//
// Handshake: a command is taken on every rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is simply "FIFO not full" and does not
// depend on cmd_valid. While cmd_ready is low the source keeps the command
// stable with cmd_valid held high.
module shift_cmd_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int DEPTH = SEQ_DEPTH,
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             left_circular,
    output logic             left_zeropad,
    output logic             right,
    output logic             noshift,
    output logic             load_now,
    output logic [WIDTH-1:0] load,
    output logic             busy,
    output logic             done,
    output logic             cmd_err,
    output logic [WIDTH-1:0] expect_out
);

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t fifo_wdata;
    cmd_t head_cmd;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    assign fifo_wdata.op    = cmd_op;
    assign fifo_wdata.count = cmd_count;
    assign fifo_wdata.data  = cmd_data;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (fifo_wdata),
        .rdata_o (head_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_e              state_q;
    logic [CNT_W-1:0]    rem_q;
    logic [NUM_CTRL-1:0] ctrl_q;
    logic [WIDTH-1:0]    load_q;
    logic [WIDTH-1:0]    expect_q;
    logic                done_q;
    logic                err_q;

    logic                head_legal;
    logic                head_is_load;
    logic                head_zero;
    logic                cur_last;

    // The running command is on its final cycle (or nothing is running),
    // so the next FIFO entry may be taken on this edge.
    assign cur_last     = (state_q == ST_IDLE) || (rem_q == '0);
    assign pop          = !fifo_empty && cur_last;

    assign head_legal   = op_is_legal(head_cmd.op);
    assign head_is_load = (head_cmd.op == 3'(OP_LOAD));
    assign head_zero    = head_legal && !head_is_load && (head_cmd.count == '0);

    // FSM: pops and classifies commands, drives the registered controls,
    // counts down the repeat count and issues done / cmd_err pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            ctrl_q  <= '0;
            load_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q == ST_EXEC && rem_q != '0) begin
                // Mid-command: hold the control and count down.
                rem_q <= rem_q - 1'b1;
            end else begin
                // The running command, if any, completes on this edge.
                if (state_q == ST_EXEC) begin
                    done_q <= 1'b1;
                end
                if (pop) begin
                    if (!head_legal) begin
                        // Illegal opcode: drop it, flag it, drive nothing.
                        err_q   <= 1'b1;
                        ctrl_q  <= '0;
                        rem_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (head_zero) begin
                        // Zero repeat: completes immediately without a control.
                        done_q  <= 1'b1;
                        ctrl_q  <= '0;
                        rem_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        // Start the new command with no bubble.
                        ctrl_q  <= op_onehot(head_cmd.op);
                        state_q <= ST_EXEC;
                        if (head_is_load) begin
                            rem_q  <= '0;
                            load_q <= head_cmd.data;
                        end else begin
                            rem_q  <= head_cmd.count - 1'b1;
                        end
                    end
                end else begin
                    ctrl_q  <= '0;
                    rem_q   <= '0;
                    state_q <= ST_IDLE;
                end
            end
        end
    end

    // Predictor: applies the same operation the shifter performs on every
    // edge where one of its controls is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            expect_q <= '0;
        end else if (ctrl_q[C_LOAD]) begin
            expect_q <= load_q;
        end else if (ctrl_q[C_ROTL]) begin
            expect_q <= {expect_q[WIDTH-2:0], expect_q[WIDTH-1]};
        end else if (ctrl_q[C_SHL]) begin
            expect_q <= {expect_q[WIDTH-2:0], 1'b0};
        end else if (ctrl_q[C_SHR]) begin
            expect_q <= {1'b0, expect_q[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign load_now      = ctrl_q[C_LOAD];
    assign left_circular = ctrl_q[C_ROTL];
    assign left_zeropad  = ctrl_q[C_SHL];
    assign right         = ctrl_q[C_SHR];
    assign noshift       = ctrl_q[C_HOLD];
    assign load          = load_q;
    assign expect_out    = expect_q;
    assign done          = done_q;
    assign cmd_err       = err_q;
    assign busy          = (state_q == ST_EXEC) || !fifo_empty;

endmodule

// File: doc/shift_cmd_sequencer.md
# shift_cmd_sequencer

Command front-end that sits directly upstream of the 8-bit shift register. It accepts queued shift/load commands over a valid/ready handshake and buffers them in a small FIFO. It then drives the shifter's one-hot control lines for the commanded number of cycles. It also maintains a cycle-exact predicted copy of the shifter contents so that downstream logic and the bench can check the datapath without probing it.

## Interface
- WIDTH, 8: data width; must match the shifter.
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- CNT_W, 4: width of the repeat count.

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_op  in  3  0=LOAD, 1=ROTL, 2=SHL (zero-fill), 3=SHR (zero-fill), 4=HOLD; 5–7 illegal.
- cmd_count  in  CNT_W  number of shift/hold cycles; ignored for LOAD.
- cmd_data  in  WIDTH  load value; used only for LOAD.
- left_circular, left_zeropad, right, noshift, load_now  out  1 each  shifter controls, registered, at most one high.
- load  out  WIDTH  shifter load bus, registered; holds the last LOAD value.
- busy  out  1  FSM in EXEC or FIFO non-empty.
- done  out  1  one-cycle pulse per completed legal command.
- cmd_err  out  1  one-cycle pulse per illegal opcode popped.
- expect_out  out  WIDTH  predicted shifter contents.

## Operation
- A command is pushed on any edge where cmd_valid && cmd_ready. There is no same-cycle bypass. A push attempted when full is not accepted, and the upstream source must hold the command.
- FSM states are IDLE and EXEC. A pop occurs on an edge where the FIFO is non-empty and the FSM is either in IDLE or in EXEC with rem==0.
- Classification of the popped entry:
  - Illegal op: dropped. cmd_err=1 next cycle, no control is asserted, and there is no done pulse.
  - count==0 with op≠LOAD: no control is asserted, and done=1 next cycle.
  - Otherwise: the matching control flop is set and the FSM enters (or stays in) EXEC with rem=count-1. For LOAD, rem=0 and load is updated to cmd_data.
- In EXEC with rem>0: the control stays high and rem decrements.
- In EXEC with rem==0, the current command completes:
  - done=1 next cycle.
  - If a pop occurs on the same edge, the new command's control is set with zero bubble.
  - Otherwise all controls clear and the FSM returns to IDLE.
- expect_out updates on every edge where a control is high:
  - ROTL: {e[W-2:0], e[W-1]}
  - SHL: {e[W-2:0], 0}
  - SHR: {0, e[W-1:1]}
  - HOLD: unchanged
  - LOAD: load
- Push and pop may occur on the same edge. Occupancy is then unchanged, and a push to a full FIFO is still blocked.

## Timing
- Reset values: all controls 0, load=0, expect_out=0, done=0, cmd_err=0, busy=0, cmd_ready=1. The FIFO is emptied and the FSM goes to IDLE.
- Reset mid-command aborts the command with no done pulse. The shifter shares the same reset, so expect_out=0 stays consistent with it.
- Latency for a command pushed at edge E0 into an idle, empty unit:
  - Pop at E1.
  - Control high for count cycles starting after E1.
  - Shifter updates at E2..E(1+count).
  - done high in the cycle after E(1+count).
- Throughput: one shifter operation per cycle with no gaps between back-to-back legal commands. Zero-count and illegal entries each consume one pop edge.
- expect_out equals the shifter output in every cycle.

## Structure
- Package shift_pkg holds:
  - the op encoding enum (OP_LOAD..OP_HOLD);
  - the FSM state enum;
  - a packed cmd_t struct {op, count, data}.
- Sub-module: sync_fifo, which is DEPTH × cmd_t with full/empty flags and a pointer wrap with an extra bit. The FSM and predictor live in the top module.

## Test plan
- Reset, then LOAD 0xA5 → load_now high for 1 cycle, load=0xA5, expect_out=0xA5, done pulses once.
- LOAD 0x81 then ROTL count=3 back-to-back → left_circular high for 3 consecutive cycles with no gap after load_now; expect_out goes 0x03, 0x06, 0x0C; two done pulses.
- SHR count=0, then op=6 → each produces no control. SHR count=0 gives 1 done pulse; op=6 gives 1 cmd_err pulse and no done pulse.
- Push 6 commands (SHL count=15 first) with cmd_valid held → cmd_ready drops after 4 entries during the stall (DEPTH=4), and every command is eventually executed in order.
- Assert reset during cycle 2 of ROTL count=8 → all controls go to 0 next cycle, expect_out=0, FIFO is empty, and no done pulse is produced.
- Random legal stream against a golden shifter model → expect_out matches the model every cycle, and no two controls are ever high together.
